// File: rtl/mux_nx1_reg_pkg.sv
// Shared definitions for the N:1 word selectors: default sizes, select-width
// helper and a flat-bus channel extractor.
package mux_pkg;

  localparam int MUX_DEF_W    = 32;
  localparam int MUX_DEF_N    = 2;
  localparam int MUX_MAX_W    = 1024;
  localparam int MUX_MAX_FLAT = 4096;

  function automatic int mux_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Callers zero-extend their bus to MUX_MAX_FLAT and keep the low w bits of the result.
  function automatic logic [MUX_MAX_W-1:0] mux_chan_extract(
    input logic [MUX_MAX_FLAT-1:0] flat,
    input int                      idx,
    input int                      w
  );
    return MUX_MAX_W'(flat >> (idx * w));
  endfunction

endpackage

// File: rtl/mux_nx1_reg_skid_buf.sv
// Two-entry valid/ready register stage with a registered upstream ready.
// Used by mux_nx1_reg when MUX_NX1_SKID_EN is defined.
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int W = MUX_DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_outData;
  logic [W-1:0] r_skidData;
  logic         r_outValid;
  logic         r_skidValid;
  logic         w_accept;
  logic         w_outFree;

  assign o_ready   = !r_skidValid;
  assign w_accept  = i_valid && !r_skidValid;
  assign w_outFree = !r_outValid || i_ready;

  // A parked word always has priority for the output register; upstream is
  // blocked while it is parked, so no new word can race it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outData   <= '0;
      r_skidData  <= '0;
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_outFree) begin
      if (r_skidValid) begin
        r_outData   <= r_skidData;
        r_outValid  <= 1'b1;
        r_skidValid <= 1'b0;
      end else if (w_accept) begin
        r_outData  <= i_data;
        r_outValid <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidData  <= i_data;
      r_skidValid <= 1'b1;
    end
  end

  assign o_data  = r_outData;
  assign o_valid = r_outValid;

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 word selector with valid/ready handshake and sticky select error.
// Define MUX_NX1_SKID_EN to add a skid register and a registered in_ready.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int W  = MUX_DEF_W,
  parameter int N  = MUX_DEF_N,
  parameter int SW = mux_sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] D_in,
  input  logic [SW-1:0]  MS,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   D_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  logic                    w_msBad;
  logic [SW-1:0]           w_idx;
  logic [MUX_MAX_FLAT-1:0] w_flat;
  logic [MUX_MAX_W-1:0]    w_chan;
  logic                    w_unusedChanBits;
  logic [W-1:0]            w_word;
  logic                    w_accept;
  logic                    r_selErr;

  // Out-of-range selects fall back to channel 0.
  assign w_msBad = (32'(MS) >= N);
  assign w_idx   = w_msBad ? '0 : MS;

  always_comb begin
    w_flat            = '0;
    w_flat[N*W-1:0]   = D_in;
  end

  assign w_chan           = mux_chan_extract(w_flat, int'(w_idx), W);
  assign w_word           = w_chan[W-1:0];
  assign w_unusedChanBits = ^w_chan[MUX_MAX_W-1:W];

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_selErr <= 1'b0;
    end else if (w_accept && w_msBad) begin
      r_selErr <= 1'b1;
    end
  end

  assign sel_err = r_selErr;

`ifdef MUX_NX1_SKID_EN
  mux_skid_buf #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_word),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .o_data  (D_out),
    .o_valid (out_valid),
    .i_ready (out_ready)
  );
`else
  logic [W-1:0] r_dOut;
  logic         r_outValid;

  assign in_ready = !r_outValid || out_ready;

  // A new word may replace the held one in the same edge that drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dOut     <= '0;
      r_outValid <= 1'b0;
    end else if (w_accept) begin
      r_dOut     <= w_word;
      r_outValid <= 1'b1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign D_out     = r_dOut;
  assign out_valid = r_outValid;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg (N = 3, W = 32) against a queue-based
// model of the accepted-word stream; honours MUX_NX1_SKID_EN.
module tb_mux_nx1_reg;
  import mux_pkg::*;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;
`ifdef MUX_NX1_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] D_in;
  logic [SW-1:0]  MS;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   D_out;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;

  logic [W-1:0] ch [N];
  logic [W-1:0] expQ [$];
  logic [W-1:0] gotQ [$];
  logic         expErr;
  logic         obsXfer;
  logic [W-1:0] obsData;
  int           assertCount = 0;
  int           failCount   = 0;

  always #5 clk = ~clk;

  mux_nx1_reg #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .D_in      (D_in),
    .MS        (MS),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D_out     (D_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  // Compares one observed value with its expectation and tallies the result.
  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle, checks outputs against the model, then advances the model.
  task automatic applyStimulus(input logic iv, input int ms, input logic ordy, output logic acc);
    logic expReady;
    logic pop;
    @(negedge clk);
    in_valid  = iv;
    MS        = SW'(ms);
    out_ready = ordy;
    D_in      = {ch[2], ch[1], ch[0]};
    #1;
    expReady = (expQ.size() < CAP) || (CAP == 1 && ordy);
    checkOutput("out_valid", W'(out_valid), W'(expQ.size() > 0));
    checkOutput("in_ready", W'(in_ready), W'(expReady));
    checkOutput("sel_err", W'(sel_err), W'(expErr));
    if (expQ.size() > 0) checkOutput("d_out", D_out, expQ[0]);
    obsXfer = out_valid && out_ready;
    obsData = D_out;
    acc = iv && expReady;
    pop = (expQ.size() > 0) && ordy;
    @(posedge clk);
    if (pop) void'(expQ.pop_front());
    if (acc) begin
      expQ.push_back((ms < N) ? ch[ms] : ch[0]);
      if (ms >= N) expErr = 1'b1;
    end
  endtask

  initial begin
    logic acc;
    int   nextWord;
    int   xfers;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; MS = '0; D_in = '0;
    expErr = 1'b0; obsXfer = 1'b0; obsData = '0;
    for (int k = 0; k < N; k++) ch[k] = '0;
    #3;
    checkOutput("rst_d_out", D_out, '0);
    checkOutput("rst_out_valid", W'(out_valid), '0);
    checkOutput("rst_sel_err", W'(sel_err), '0);
    checkOutput("rst_in_ready", W'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] selection");
    ch[0] = 32'h11111111; ch[1] = 32'h22222222; ch[2] = 32'h33333333;
    applyStimulus(1'b1, 2, 1'b1, acc);
    #1;
    checkOutput("sel_ms2", D_out, 32'h33333333);
    checkOutput("sel_valid", W'(out_valid), 32'd1);

    $display("[TB] out-of-range select");
    applyStimulus(1'b1, 3, 1'b1, acc);
    #1;
    checkOutput("oor_d_out", D_out, 32'h11111111);
    checkOutput("oor_sel_err", W'(sel_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < N; k++) ch[k] = $urandom;
      applyStimulus(1'b1, int'($urandom_range(0, 2)), 1'b1, acc);
    end
    #1;
    checkOutput("oor_sticky", W'(sel_err), 32'd1);
    applyStimulus(1'b0, 0, 1'b1, acc);

    $display("[TB] backpressure");
    nextWord = 1;
    gotQ.delete();
    for (int c = 1; c <= 40 && gotQ.size() < 8; c++) begin
      ch[0] = W'(nextWord);
      applyStimulus(nextWord <= 8, 0, !(c >= 3 && c <= 5), acc);
      if (obsXfer) gotQ.push_back(obsData);
      if (acc) nextWord++;
    end
    checkOutput("bp_count", W'(gotQ.size()), 32'd8);
    for (int i = 0; i < gotQ.size(); i++) checkOutput("bp_order", gotQ[i], W'(i + 1));

    $display("[TB] throughput");
    xfers = 0;
    for (int c = 0; c < 101; c++) begin
      ch[1] = W'(32'h1000 + c);
      applyStimulus(c < 100, 1, 1'b1, acc);
      if (obsXfer) xfers++;
      if (c >= 2 && c <= 100) checkOutput("tp_valid_held", W'(out_valid), 32'd1);
    end
    checkOutput("tp_transfers", W'(xfers), 32'd100);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) ch[k] = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) != 0), acc);
    end

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 0, 1'b1, acc);
    applyStimulus(1'b0, 0, 1'b1, acc);
    ch[0] = 32'hAAAA0001; ch[1] = 32'hAAAA0002; ch[2] = 32'hAAAA0003;
    applyStimulus(1'b1, 3, 1'b0, acc);
    applyStimulus(1'b1, 1, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_d_out", D_out, '0);
    checkOutput("mid_rst_out_valid", W'(out_valid), '0);
    checkOutput("mid_rst_sel_err", W'(sel_err), '0);
    checkOutput("mid_rst_in_ready", W'(in_ready), 32'd1);
    expQ.delete();
    expErr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b1, acc);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
